// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder types and constants used by the traceback output stage.
package viterbi_pkg;
    localparam int TB_BLOCK_LEN = 8;
    typedef logic bank_sel_t;
    typedef logic [$clog2(TB_BLOCK_LEN)-1:0] tb_ptr_t;
endpackage

// File: rtl/lifo_bank.sv
// One ping-pong bank: bit storage, full flag, write port and asynchronous read mux.
module lifo_bank #(
    parameter int LEN = 8,
    parameter int AW  = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic          i_set_full,
    input  logic          i_clr_full,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata,
    output logic          o_full
);
    logic [LEN-1:0] r_mem;
    logic           r_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem  <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_wr)
                r_mem[i_waddr] <= i_wdata;
            // Set and clear never coincide: a bank being drained is full and rejects writes.
            if (i_set_full)
                r_full <= 1'b1;
            else if (i_clr_full)
                r_full <= 1'b0;
        end
    end

    assign o_rdata = r_mem[i_raddr];
    assign o_full  = r_full;
endmodule

// File: rtl/tbu_lifo.sv
// Traceback output reversal: collects newest-first blocks and replays them oldest-first.
module tbu_lifo
    import viterbi_pkg::*;
#(
    parameter int BLOCK_LEN = TB_BLOCK_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic d_in,
    input  logic flush,
    output logic d_o,
    output logic d_o_valid,
    input  logic d_o_ready,
    output logic overflow
);
    localparam int PW = $clog2(BLOCK_LEN);
    localparam logic [PW-1:0] LAST = PW'(BLOCK_LEN - 1);

    bank_sel_t     r_wbank, r_rbank;
    logic [PW-1:0] r_wptr, r_rptr;
    logic          r_overflow;

    logic [1:0] w_full, w_rdata;
    logic       w_wr_acc, w_wr_last, w_wr_drop, w_hs, w_rd_last;

    assign w_wr_acc  = wr_en && !flush && !w_full[r_wbank];
    assign w_wr_drop = wr_en && !flush &&  w_full[r_wbank];
    assign w_wr_last = w_wr_acc && (r_wptr == LAST);
    assign w_hs      = w_full[r_rbank] && d_o_ready;
    assign w_rd_last = w_hs && (r_rptr == '0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            lifo_bank #(.LEN(BLOCK_LEN), .AW(PW)) u_bank (
                .clk        (clk),
                .rst        (rst),
                .i_wr       (w_wr_acc  && (r_wbank == 1'(gi))),
                .i_waddr    (r_wptr),
                .i_wdata    (d_in),
                .i_set_full (w_wr_last && (r_wbank == 1'(gi))),
                .i_clr_full (w_rd_last && (r_rbank == 1'(gi))),
                .i_raddr    (r_rptr),
                .o_rdata    (w_rdata[gi]),
                .o_full     (w_full[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= LAST;
            r_overflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wptr <= '0;
            end else if (w_wr_acc) begin
                if (w_wr_last) begin
                    r_wptr  <= '0;
                    r_wbank <= ~r_wbank;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
            end
            if (w_wr_drop)
                r_overflow <= 1'b1;
            // Reading starts at the last-written slot so each block comes out reversed.
            if (w_hs) begin
                if (w_rd_last) begin
                    r_rptr  <= LAST;
                    r_rbank <= ~r_rbank;
                end else begin
                    r_rptr <= r_rptr - 1'b1;
                end
            end
        end
    end

    assign d_o_valid = w_full[r_rbank];
    assign d_o       = w_full[r_rbank] ? w_rdata[r_rbank] : 1'b0;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_tbu_lifo.sv
// Randomized and directed scoreboard bench for the tbu_lifo reversal stage.
module tb_tbu_lifo;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0, d_in = 1'b0, flush = 1'b0, d_o_ready = 1'b0;
    logic d_o, d_o_valid, overflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model: list of pending output bits, completed-but-undrained
    // block count, partial input block, sticky overflow.
    bit exp_q[$];
    bit part_q[$];
    int held = 0;
    int out_cnt = 0;
    bit exp_ovf = 1'b0;
    bit started = 1'b0;
    int bits_out = 0;

    tbu_lifo #(.BLOCK_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .d_in      (d_in),
        .flush     (flush),
        .d_o       (d_o),
        .d_o_valid (d_o_valid),
        .d_o_ready (d_o_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor and model step: compare outputs before the edge, then apply the
    // effects of the inputs that will be sampled at the coming edge.
    always @(negedge clk) begin
        int held_pre;
        bit ev;
        bit eb;
        held_pre = held;
        ev = (held > 0);
        if (started) begin
            chk("valid", int'(d_o_valid), int'(ev));
            chk("overflow", int'(overflow), int'(exp_ovf));
            if (!ev)
                chk("idle_d_o", int'(d_o), 0);
        end
        if (!rst) begin
            exp_q.delete();
            part_q.delete();
            held = 0;
            out_cnt = 0;
            exp_ovf = 1'b0;
            started = 1'b1;
        end else if (started) begin
            if (ev && d_o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("d_o", int'(d_o), int'(eb));
                    $display("out bit %0d d_o=%0d exp=%0d", bits_out, d_o, eb);
                    bits_out++;
                end
                out_cnt++;
                if (out_cnt == BL) begin
                    out_cnt = 0;
                    held--;
                end
            end
            if (flush) begin
                part_q.delete();
            end else if (wr_en) begin
                if (held_pre < 2) begin
                    part_q.push_back(d_in);
                    if (part_q.size() == BL) begin
                        for (int i = BL - 1; i >= 0; i--)
                            exp_q.push_back(part_q[i]);
                        part_q.delete();
                        held++;
                    end
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic we, input logic d,
                         input logic fl, input logic rdy);
        rst = r; wr_en = we; d_in = d; flush = fl; d_o_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic write_bits(input logic [31:0] bits, input int n, input logic rdy);
        for (int i = n - 1; i >= 0; i--)
            drive(1'b1, 1'b1, bits[i], 1'b0, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    initial begin
        // 1: reset with writes asserted
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // 2: one block, written 1,0,1,1,0,0,0,1
        write_bits(32'b10110001, 8, 1'b1);
        idle(10, 1'b1);
        // 3: two blocks held, 17th write dropped, then drain
        write_bits(32'hA5C3, 16, 1'b0);
        write_bits(32'h1, 1, 1'b0);
        idle(20, 1'b1);
        // 4: continuous traffic across bank swaps
        for (int i = 0; i < 32; i++)
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle(12, 1'b1);
        // 5: flush a partial block, then flush together with a write
        write_bits(32'b101, 3, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        write_bits(32'b11110000, 8, 1'b1);
        write_bits(32'b011, 3, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        write_bits(32'b11001010, 8, 1'b1);
        idle(12, 1'b1);
        // 6: reset midway through draining a block
        write_bits(32'b10010110, 8, 1'b0);
        idle(4, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        write_bits(32'b11100100, 8, 1'b1);
        idle(10, 1'b1);
        // Random traffic including flushes, stalls and occasional resets
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 6));
        // Bounded drain: everything completed must have come out
        idle(2 * BL + 4, 1'b1);
        chk("drained", exp_q.size(), 0);
        chk("some_output", int'(bits_out > 100), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
